autoc_lag_accum: RTL

Runtime-programmable lagged complex autocorrelator for the USRP2 RX path. It consumes strobed {I16,Q16} samples from the DDC chain and forms z[n] = x[n]·conj(x[n−lag]). It sums z over back-to-back windows of 2^LOG_LEN products and emits one full-precision complex result per window with a strobe. It generalises the fixed-lag I·I-only autocorrelator to full complex products, a programmable lag, window integration and stream control.

---
 rtl/autoc_lag_accum_if.sv | 29 ++
 rtl/autoc_lag_accum.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/autoc_lag_accum_if.sv
// Sample-stream and result bus of the lagged complex autocorrelator.
// The DUT attaches through the slave modport; the feeding/consuming side uses master.
interface autoc_lag_accum_if #(
    parameter int LAG_W   = 6,
    parameter int LOG_LEN = 10
);
    localparam int ACC_W = 33 + LOG_LEN;

    logic                    run;
    logic [LAG_W-1:0]        lag;
    logic                    ddc_out_enable;
    logic [31:0]             ddc_out_sample;
    logic                    ddc_out_strobe;
    logic signed [ACC_W-1:0] si;
    logic signed [ACC_W-1:0] sq;
    logic signed [ACC_W-1:0] power;
    logic                    out_strobe;
    logic                    outputting;

    modport master (
        output run, lag, ddc_out_sample, ddc_out_strobe,
        input  ddc_out_enable, si, sq, power, out_strobe, outputting
    );

    modport slave (
        input  run, lag, ddc_out_sample, ddc_out_strobe,
        output ddc_out_enable, si, sq, power, out_strobe, outputting
    );
endinterface

// File: rtl/autoc_lag_accum.sv
// Lagged complex autocorrelator: sums x[n]*conj(x[n-lag]) over windows of 2^LOG_LEN products.
// Define AUTOC_POWER_EN to add a |x|^2 window accumulator on the power port.
module autoc_lag_accum #(
    parameter int LAG_W   = 6,
    parameter int LOG_LEN = 10
) (
    input  logic             clk,
    input  logic             rst,
    autoc_lag_accum_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int ACC_W  = SUM_W + LOG_LEN;

    typedef enum logic [1:0] {IDLE, FILL, ACCUM} state_t;
    state_t state, next_state;

    logic [LAG_W-1:0]   lag_q, wr_ptr, fill_cnt, rd_addr;
    logic [LOG_LEN-1:0] prod_cnt;
    logic               accept;
    logic [31:0]        ram [2**LAG_W];
    logic [31:0]        del_word;

    logic                     vld_p0, first_p0, last_p0;
    logic signed [DATA_W-1:0] ci_p0, cq_p0, di_p0, dq_p0;
    logic                     vld_p1, first_p1, last_p1;
    logic signed [PROD_W-1:0] ii_p1, qq_p1, qi_p1, iq_p1;
    logic signed [SUM_W-1:0]  re_p2, im_p2;
    logic signed [ACC_W-1:0]  acc_re, acc_im, acc_re_nxt, acc_im_nxt;
    logic                     take_p2;

    function automatic logic signed [PROD_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
        logic signed [PROD_W-1:0] ax, bx;
        ax = PROD_W'(a);
        bx = PROD_W'(b);
        return ax * bx;
    endfunction

    function automatic logic signed [SUM_W-1:0] add2(input logic signed [PROD_W-1:0] a,
                                                     input logic signed [PROD_W-1:0] b);
        return SUM_W'(a) + SUM_W'(b);
    endfunction

    function automatic logic signed [SUM_W-1:0] sub2(input logic signed [PROD_W-1:0] a,
                                                     input logic signed [PROD_W-1:0] b);
        return SUM_W'(a) - SUM_W'(b);
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [SUM_W-1:0] v);
        return ACC_W'(v);
    endfunction

    // A strobe in the cycle run falls is dropped, as is anything seen while IDLE.
    assign accept   = bus.run && bus.ddc_out_strobe && (state != IDLE);
    assign rd_addr  = wr_ptr - lag_q;
    assign del_word = (lag_q == '0) ? bus.ddc_out_sample : ram[rd_addr];
    assign take_p2  = vld_p1 && bus.run;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.run) next_state = (bus.lag == '0) ? ACCUM : FILL;
            FILL:    if (!bus.run) next_state = IDLE;
                     else if (accept && fill_cnt == lag_q - LAG_W'(1)) next_state = ACCUM;
            ACCUM:   if (!bus.run) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            bus.ddc_out_enable <= 1'b0;
            lag_q              <= '0;
            wr_ptr             <= '0;
            fill_cnt           <= '0;
            prod_cnt           <= '0;
            vld_p0             <= 1'b0;
            first_p0           <= 1'b0;
            last_p0            <= 1'b0;
            vld_p1             <= 1'b0;
            first_p1           <= 1'b0;
            last_p1            <= 1'b0;
            bus.out_strobe     <= 1'b0;
            bus.outputting     <= 1'b0;
            bus.si             <= '0;
            bus.sq             <= '0;
        end else begin
            state              <= next_state;
            bus.ddc_out_enable <= (next_state != IDLE);
            if (state == IDLE && bus.run) lag_q <= bus.lag;
            if (!bus.run) begin
                wr_ptr   <= '0;
                fill_cnt <= '0;
                prod_cnt <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + LAG_W'(1);
                if (state == FILL) fill_cnt <= fill_cnt + LAG_W'(1);
                else               prod_cnt <= prod_cnt + LOG_LEN'(1);
            end
            // p0 -> p1 -> p2 valids; dropping run flushes whatever is in flight.
            vld_p0         <= accept && (state == ACCUM);
            first_p0       <= (prod_cnt == '0);
            last_p0        <= (prod_cnt == '1);
            vld_p1         <= vld_p0 && bus.run;
            first_p1       <= first_p0;
            last_p1        <= last_p0;
            bus.out_strobe <= take_p2 && last_p1;
            if (take_p2 && last_p1) begin
                bus.si <= acc_re_nxt;
                bus.sq <= acc_im_nxt;
            end
            if (!bus.run)                bus.outputting <= 1'b0;
            else if (take_p2 && last_p1) bus.outputting <= 1'b1;
        end
    end

    // p0: delay-line write/read and operand capture
    always_ff @(posedge clk) begin
        if (accept) begin
            ram[wr_ptr] <= bus.ddc_out_sample;
            ci_p0       <= bus.ddc_out_sample[31:16];
            cq_p0       <= bus.ddc_out_sample[15:0];
            di_p0       <= del_word[31:16];
            dq_p0       <= del_word[15:0];
        end
        // p1: four cross products
        if (vld_p0) begin
            ii_p1 <= mul(ci_p0, di_p0);
            qq_p1 <= mul(cq_p0, dq_p0);
            qi_p1 <= mul(cq_p0, di_p0);
            iq_p1 <= mul(ci_p0, dq_p0);
        end
        // p2: window accumulation
        if (take_p2) begin
            acc_re <= acc_re_nxt;
            acc_im <= acc_im_nxt;
        end
    end

    always_comb begin
        re_p2      = add2(ii_p1, qq_p1);
        im_p2      = sub2(qi_p1, iq_p1);
        acc_re_nxt = first_p1 ? sext(re_p2) : acc_re + sext(re_p2);
        acc_im_nxt = first_p1 ? sext(im_p2) : acc_im + sext(im_p2);
    end

`ifdef AUTOC_POWER_EN
    logic signed [PROD_W-1:0] pi_p1, pq_p1;
    logic signed [SUM_W-1:0]  pw_p2;
    logic signed [ACC_W-1:0]  acc_pw, acc_pw_nxt;

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            pi_p1 <= mul(ci_p0, ci_p0);
            pq_p1 <= mul(cq_p0, cq_p0);
        end
        if (take_p2) acc_pw <= acc_pw_nxt;
    end

    always_comb begin
        pw_p2      = add2(pi_p1, pq_p1);
        acc_pw_nxt = first_p1 ? sext(pw_p2) : acc_pw + sext(pw_p2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     bus.power <= '0;
        else if (take_p2 && last_p1) bus.power <= acc_pw_nxt;
    end
`else
    assign bus.power = '0;
`endif
endmodule
